control_sequencer: RTL

- Hardwired multi-cycle control unit for the phase-1 bus datapath.
- Fetches each instruction and decodes IR; then issues the one-hot Rin/Rout, PC/MAR/MDR/IR/Y/Z/HI/LO strobes and ALUop, one step per clock.
- Replaces the hand-written per-instruction state machines in the benches; stalls on a memory-ready handshake for every read and write.

---
 rtl/control_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit for the phase-1 bus datapath: fetch, decode IR,
// then one Moore-decoded control step per clock with memory-ready stalls on Read/Write.
module control_sequencer #(
    parameter int                 REG_COUNT = 16,
    parameter int                 ALUOP_W   = 4,
    parameter logic [ALUOP_W-1:0] ADD_OP    = '0
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 run,
    input  logic [31:0]          IR,
    input  logic                 mem_ready,
    output logic [REG_COUNT-1:0] Rin,
    output logic [REG_COUNT-1:0] Rout,
    output logic                 PCin,
    output logic                 PCout,
    output logic                 IncPC,
    output logic                 MARin,
    output logic                 MDRin,
    output logic                 MDRout,
    output logic                 Read,
    output logic                 Write,
    output logic                 IRin,
    output logic                 Yin,
    output logic                 Zhighin,
    output logic                 Zlowin,
    output logic                 Zhighout,
    output logic                 Zlowout,
    output logic                 HIin,
    output logic                 HIout,
    output logic                 LOin,
    output logic                 LOout,
    output logic                 Cout,
    output logic [ALUOP_W-1:0]   ALUop,
    output logic                 halted,
    output logic [4:0]           state
);

    typedef enum logic [4:0] {
        S_IDLE = 5'd0,
        S_T0   = 5'd1,
        S_T1   = 5'd2,
        S_T2   = 5'd3,
        S_T3   = 5'd4,
        S_T4   = 5'd5,
        S_T5   = 5'd6,
        S_T6   = 5'd7,
        S_T7   = 5'd8,
        S_HALT = 5'h1F
    } state_e;

    localparam logic [4:0] OP_ALU_LAST = 5'h0B;
    localparam logic [4:0] OP_DIV      = 5'h0C;
    localparam logic [4:0] OP_MUL      = 5'h0D;
    localparam logic [4:0] OP_ADDI     = 5'h10;
    localparam logic [4:0] OP_LD       = 5'h11;
    localparam logic [4:0] OP_ST       = 5'h12;
    localparam logic [4:0] OP_MFHI     = 5'h1B;
    localparam logic [4:0] OP_MFLO     = 5'h1C;
    localparam logic [4:0] OP_HALT     = 5'h1F;

    state_e state_q, state_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_muldiv, is_addi, is_ld, is_st, is_mfhi, is_mflo, is_halt;
    logic       is_mem, is_imm, uses_ybus;
    logic [REG_COUNT-1:0] ra_oh, rb_oh, rc_oh;
    state_e     end_state;

    // Low IR bits are the immediate; the datapath sign-extends them itself under Cout.
    logic unused_ir;
    assign unused_ir = ^IR[14:0];

    assign opcode = IR[31:27];
    assign ra     = IR[26:23];
    assign rb     = IR[22:19];
    assign rc     = IR[18:15];

    assign is_alu    = (opcode <= OP_ALU_LAST);
    assign is_muldiv = (opcode == OP_DIV) || (opcode == OP_MUL);
    assign is_addi   = (opcode == OP_ADDI);
    assign is_ld     = (opcode == OP_LD);
    assign is_st     = (opcode == OP_ST);
    assign is_mfhi   = (opcode == OP_MFHI);
    assign is_mflo   = (opcode == OP_MFLO);
    assign is_halt   = (opcode == OP_HALT);
    assign is_mem    = is_ld | is_st;
    assign is_imm    = is_addi | is_mem;
    assign uses_ybus = is_alu | is_muldiv | is_imm;

    // Out-of-range selects shift the single bit off the end, giving no select at all.
    assign ra_oh = REG_COUNT'(1) << ra;
    assign rb_oh = REG_COUNT'(1) << rb;
    assign rc_oh = REG_COUNT'(1) << rc;

    assign end_state = run ? S_T0 : S_IDLE;
    assign state     = state_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        Rin      = '0;
        Rout     = '0;
        PCin     = 1'b0;
        PCout    = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zhighin  = 1'b0;
        Zlowin   = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        HIin     = 1'b0;
        HIout    = 1'b0;
        LOin     = 1'b0;
        LOout    = 1'b0;
        Cout     = 1'b0;
        ALUop    = '0;
        halted   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zlowin  = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                // Re-loading PC from Z while stalled is idempotent.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (uses_ybus) begin
                    Rout    = rb_oh;
                    Yin     = 1'b1;
                    state_d = S_T4;
                end else if (is_mfhi) begin
                    HIout   = 1'b1;
                    Rin     = ra_oh;
                    state_d = end_state;
                end else if (is_mflo) begin
                    LOout   = 1'b1;
                    Rin     = ra_oh;
                    state_d = end_state;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = end_state;
                end
            end
            S_T4: begin
                Zlowin = 1'b1;
                if (is_imm) begin
                    Cout  = 1'b1;
                    ALUop = ADD_OP;
                end else begin
                    Rout    = rc_oh;
                    ALUop   = ALUOP_W'(opcode[3:0]);
                    Zhighin = is_muldiv;
                end
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else if (is_mem) begin
                    MARin   = 1'b1;
                    state_d = S_T6;
                end else begin
                    Rin     = ra_oh;
                    state_d = end_state;
                end
            end
            S_T6: begin
                if (is_muldiv) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                    state_d  = end_state;
                end else if (is_ld) begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                    if (mem_ready) state_d = S_T7;
                end else begin
                    Rout    = ra_oh;
                    MDRin   = 1'b1;
                    state_d = S_T7;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout  = 1'b1;
                    Rin     = ra_oh;
                    state_d = end_state;
                end else begin
                    Write = 1'b1;
                    if (mem_ready) state_d = end_state;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
